// File: rtl/dmac_write_response_tracker.sv
// Tracks outstanding AXI write bursts in issue order, retires one per B response,
// accumulates per-channel errors and reports per-transfer completion.
module dmac_write_response_tracker #(
  parameter int CHANNEL_COUNT   = 8,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CH_WD  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int CNT_WD = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              burst_issue_valid,
  output logic              burst_issue_ready,
  input  logic [CH_WD-1:0]  burst_issue_channel,
  input  logic              burst_issue_last,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              xfer_done_valid,
  input  logic              xfer_done_ready,
  output logic [CH_WD-1:0]  xfer_done_channel,
  output logic [1:0]        xfer_done_resp,
  output logic [CNT_WD-1:0] outstanding_count,
  output logic              idle
);

  localparam int PTR_WD = $clog2(MAX_OUTSTANDING);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [CNT_WD-1:0] FULL_COUNT = CNT_WD'(MAX_OUTSTANDING);

  logic [CH_WD-1:0]  fifoCh_q   [MAX_OUTSTANDING];
  logic              fifoLast_q [MAX_OUTSTANDING];
  logic [PTR_WD-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_WD-1:0] count_q, count_d;
  logic [1:0]        err_q [CHANNEL_COUNT];
  logic              doneValid_q;
  logic [CH_WD-1:0]  doneCh_q;
  logic [1:0]        doneResp_q;

  logic              push, pop;
  logic [CH_WD-1:0]  headCh;
  logic              headLast;
  logic [1:0]        headErr;

  assign headCh   = fifoCh_q[rdPtr_q];
  assign headLast = fifoLast_q[rdPtr_q];
  assign headErr  = err_q[headCh];

  // A last-burst response may only retire when the completion register can take it.
  assign burst_issue_ready = (count_q != FULL_COUNT);
  assign m_axi_bready      = (count_q != '0) && (!doneValid_q || xfer_done_ready || !headLast);
  assign push              = burst_issue_valid && burst_issue_ready;
  assign pop               = m_axi_bvalid && m_axi_bready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_WD'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_WD'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifoCh_q[i]   <= '0;
        fifoLast_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        fifoCh_q[wrPtr_q]   <= burst_issue_channel;
        fifoLast_q[wrPtr_q] <= burst_issue_last;
        wrPtr_q             <= wrPtr_q + PTR_WD'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_WD'(1);
      end
    end
  end

  // Only the first non-OKAY response of a transfer is kept; the last burst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        err_q[i] <= RESP_OKAY;
      end
    end else if (pop) begin
      if (headLast) begin
        err_q[headCh] <= RESP_OKAY;
      end else if (m_axi_bresp != RESP_OKAY && headErr == RESP_OKAY) begin
        err_q[headCh] <= m_axi_bresp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doneValid_q <= 1'b0;
      doneCh_q    <= '0;
      doneResp_q  <= RESP_OKAY;
    end else if (pop && headLast) begin
      doneValid_q <= 1'b1;
      doneCh_q    <= headCh;
      doneResp_q  <= (headErr != RESP_OKAY) ? headErr : m_axi_bresp;
    end else if (doneValid_q && xfer_done_ready) begin
      doneValid_q <= 1'b0;
    end
  end

  assign xfer_done_valid   = doneValid_q;
  assign xfer_done_channel = doneCh_q;
  assign xfer_done_resp    = doneResp_q;
  assign outstanding_count = count_q;
  assign idle              = (count_q == '0) && !doneValid_q;

  pushWhileFull: assert property (@(posedge clk) disable iff (rst)
    burst_issue_valid |-> burst_issue_ready);

  acceptWhileEmpty: assert property (@(posedge clk) disable iff (rst)
    (m_axi_bvalid && count_q == '0) |-> !m_axi_bready);

endmodule
